// File: rtl/game_pkg.sv
// Constants, state encodings, sound codes and the row expansion shared by the scheduler and the game logic.
// Holds no logic of its own; the game core imports the same speed constants.
package game_pkg;

  localparam logic [31:0] BASE_PERIOD_DEF  = 32'd25_000_000;
  localparam logic [31:0] MIN_PERIOD_DEF   = 32'd5_000_000;
  localparam logic [31:0] STEP_DEF         = 32'd100_000;
  localparam int unsigned FIFO_DEPTH_DEF   = 4;
  localparam int unsigned SPAWN_THRESH_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2,
    S_PAUSE = 2'd3
  } sched_state_t;

  typedef enum logic [2:0] {
    SND_NONE      = 3'd0,
    SND_PERFECT   = 3'd1,
    SND_GOOD      = 3'd2,
    SND_MISS      = 3'd3,
    SND_LEVEL_UP  = 3'd4,
    SND_GAME_OVER = 3'd5
  } snd_cmd_t;

  // Each of the four high random bits becomes a two-lane note; weak low nibbles spawn nothing.
  function automatic logic [7:0] expand_row(input logic [7:0] rnd, input logic [4:0] thresh);
    logic [7:0] row;
    row = 8'd0;
    if ({1'b0, rnd[3:0]} >= thresh) begin
      row = {rnd[7], rnd[7], rnd[6], rnd[6], rnd[5], rnd[5], rnd[4], rnd[4]};
    end
    return row;
  endfunction

endpackage

// File: rtl/note_scheduler_row_fifo.sv
// row_fifo: synchronous pending-row buffer; push and pop in the same cycle, flush empties it.
// Head is read combinationally; pushes are dropped when full unless a pop frees the slot.
module row_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LV = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (level_q != '0);
    do_push  = push && ((level_q != FULL_LV) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign level    = level_q;
  assign empty    = (level_q == '0);

endmodule

// File: rtl/note_scheduler.sv
// note_scheduler: fall-tick sequencer with pending-row FIFO and hit-driven speed ramp; all outputs registered.
// Optional head preview on o_Next_Row is enabled by defining NOTE_SCHED_PREVIEW_EN.
module note_scheduler
  import game_pkg::*;
#(
  parameter logic [31:0] BASE_PERIOD  = BASE_PERIOD_DEF,
  parameter logic [31:0] MIN_PERIOD   = MIN_PERIOD_DEF,
  parameter logic [31:0] STEP         = STEP_DEF,
  parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int unsigned SPAWN_THRESH = SPAWN_THRESH_DEF
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst,
  input  logic                          i_Start,
  input  logic                          i_Stop,
  input  logic                          i_Pause,
  input  logic [1:0]                    i_Speed_Opt,
  input  logic                          i_Hit,
  input  logic [7:0]                    i_Rand_Val,
  input  logic                          i_Rand_Valid,
  output logic                          o_Tick,
  output logic [7:0]                    o_Row,
  output logic [31:0]                   o_Phase,
  output logic [31:0]                   o_Period,
  output logic                          o_Running,
  output logic                          o_Underrun,
  output logic [$clog2(FIFO_DEPTH):0]   o_Level,
  output logic [7:0]                    o_Next_Row
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LV    = LW'(FIFO_DEPTH);
  localparam logic [4:0]    THRESH     = 5'(SPAWN_THRESH);
  localparam logic [31:0]   RAMP_FLOOR = MIN_PERIOD + STEP;

  sched_state_t state_q, state_d;
  logic [31:0]  phase_q, phase_d;
  logic [31:0]  period_q, period_d;
  logic         tick_q, tick_d;
  logic         underrun_q, underrun_d;
  logic [7:0]   row_q, row_d;

  logic [31:0]  speed_period;
  logic [31:0]  ramp_period;
  logic [31:0]  eff_period;
  logic         fifo_pop;
  logic [7:0]   fifo_head;
  logic [7:0]   push_row;
  logic [LW-1:0] fifo_level;
  logic         fifo_empty;

  assign push_row = expand_row(i_Rand_Val, THRESH);

  row_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_row_fifo (
    .clk      (i_Clk),
    .rst      (i_Rst),
    .flush    (i_Stop),
    .push     (i_Rand_Valid),
    .push_dat (push_row),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .level    (fifo_level),
    .empty    (fifo_empty)
  );

  always_comb begin
    case (i_Speed_Opt)
      2'b01:   speed_period = BASE_PERIOD >> 1;
      2'b10:   speed_period = BASE_PERIOD >> 2;
      default: speed_period = BASE_PERIOD;
    endcase
  end

  // Subtract only when it cannot dip below the floor, so the period never wraps.
  assign ramp_period = (period_q >= RAMP_FLOOR) ? (period_q - STEP) : MIN_PERIOD;
  assign eff_period  = ((state_q == S_RUN) && i_Hit) ? ramp_period : period_q;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      period_q   <= BASE_PERIOD;
      tick_q     <= 1'b0;
      row_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      period_q   <= period_d;
      tick_q     <= tick_d;
      row_q      <= row_d;
      underrun_q <= underrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_Stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (i_Start) state_d = S_PRIME;
        S_PRIME: if (fifo_level == FULL_LV) state_d = S_RUN;
        S_RUN:   if (i_Pause) state_d = S_PAUSE;
        S_PAUSE: if (!i_Pause) state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // The compare uses the post-hit period so a hit that overtakes the phase ticks on the next cycle.
  always_comb begin
    phase_d    = phase_q;
    period_d   = period_q;
    tick_d     = 1'b0;
    row_d      = '0;
    underrun_d = 1'b0;
    fifo_pop   = 1'b0;
    if (i_Stop) begin
      phase_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          period_d = speed_period;
          phase_d  = '0;
        end
        S_RUN: begin
          period_d = eff_period;
          if (!i_Pause) begin
            if (phase_q >= eff_period) begin
              tick_d     = 1'b1;
              phase_d    = '0;
              fifo_pop   = !fifo_empty;
              row_d      = fifo_empty ? 8'd0 : fifo_head;
              underrun_d = fifo_empty;
            end else begin
              phase_d = phase_q + 32'd1;
            end
          end
        end
        default: begin
          phase_d = phase_q;
        end
      endcase
    end
  end

  assign o_Tick     = tick_q;
  assign o_Row      = row_q;
  assign o_Phase    = phase_q;
  assign o_Period   = period_q;
  assign o_Running  = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign o_Underrun = underrun_q;
  assign o_Level    = fifo_level;

`ifdef NOTE_SCHED_PREVIEW_EN
  assign o_Next_Row = fifo_empty ? 8'd0 : fifo_head;
`else
  assign o_Next_Row = 8'd0;
`endif

endmodule

// File: tb/tb_note_scheduler.sv
// Bench for note_scheduler: scaled periods (BASE 100, STEP 30, MIN 20), queue-based reference model
// compared every cycle, plus directed literal checks for each scenario.
module tb_note_scheduler;

  localparam int BASE  = 100;
  localparam int MINP  = 20;
  localparam int STEPV = 30;
  localparam int DEPTH = 4;

  localparam int M_IDLE  = 0;
  localparam int M_PRIME = 1;
  localparam int M_RUN   = 2;
  localparam int M_PAUSE = 3;

  logic        clk = 1'b0;
  logic        rst, start, stop, pause, hit, rv;
  logic [1:0]  speed;
  logic [7:0]  rval;

  logic        o_Tick;
  logic [7:0]  o_Row;
  logic [31:0] o_Phase;
  logic [31:0] o_Period;
  logic        o_Running;
  logic        o_Underrun;
  logic [2:0]  o_Level;
  logic [7:0]  o_Next_Row;

  note_scheduler #(
    .BASE_PERIOD  (32'(BASE)),
    .MIN_PERIOD   (32'(MINP)),
    .STEP         (32'(STEPV)),
    .FIFO_DEPTH   (DEPTH),
    .SPAWN_THRESH (8)
  ) dut (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_Start      (start),
    .i_Stop       (stop),
    .i_Pause      (pause),
    .i_Speed_Opt  (speed),
    .i_Hit        (hit),
    .i_Rand_Val   (rval),
    .i_Rand_Valid (rv),
    .o_Tick       (o_Tick),
    .o_Row        (o_Row),
    .o_Phase      (o_Phase),
    .o_Period     (o_Period),
    .o_Running    (o_Running),
    .o_Underrun   (o_Underrun),
    .o_Level      (o_Level),
    .o_Next_Row   (o_Next_Row)
  );

  initial forever #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  int         m_mode;
  logic [7:0] m_q[$];
  longint     m_phase, m_period;
  bit         m_tick, m_und;
  logic [7:0] m_row;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name, input int bound);
    n_vec++;
    n_err++;
    $display("FAIL %s: event not seen within %0d cycles, expected it", name, bound);
  endtask

  function automatic longint speed_of(input logic [1:0] s);
    case (s)
      2'b01:   return BASE / 2;
      2'b10:   return BASE / 4;
      default: return BASE;
    endcase
  endfunction

  function automatic logic [7:0] row_of(input logic [7:0] r);
    logic [7:0] row;
    row = 8'd0;
    if (r[3:0] >= 4'd8) begin
      for (int i = 0; i < 4; i++) begin
        row[2*i]   = r[4+i];
        row[2*i+1] = r[4+i];
      end
    end
    return row;
  endfunction

  task automatic model_step();
    m_tick = 1'b0;
    m_row  = 8'd0;
    m_und  = 1'b0;
    if (rst) begin
      m_mode = M_IDLE; m_phase = 0; m_period = BASE; m_q.delete();
      return;
    end
    if (stop) begin
      m_mode = M_IDLE; m_phase = 0; m_q.delete();
      return;
    end
    case (m_mode)
      M_IDLE: begin
        m_period = speed_of(speed);
        m_phase  = 0;
        if (start) m_mode = M_PRIME;
      end
      M_PRIME: if (m_q.size() == DEPTH) m_mode = M_RUN;
      M_RUN: begin
        if (hit) m_period = (m_period - STEPV < MINP) ? MINP : m_period - STEPV;
        if (pause) m_mode = M_PAUSE;
        else if (m_phase >= m_period) begin
          m_tick  = 1'b1;
          m_phase = 0;
          if (m_q.size() > 0) m_row = m_q.pop_front();
          else m_und = 1'b1;
        end else m_phase++;
      end
      M_PAUSE: if (!pause) m_mode = M_RUN;
      default: m_mode = M_IDLE;
    endcase
    if (rv && m_q.size() < DEPTH) m_q.push_back(row_of(rval));
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    model_step();
  end

  initial forever begin
    logic [7:0] exp_next;
    @(negedge clk);
    if (chk_en) begin
      exp_next = 8'd0;
`ifdef NOTE_SCHED_PREVIEW_EN
      if (m_q.size() > 0) exp_next = m_q[0];
`endif
      chk("m_tick",     o_Tick,     m_tick);
      chk("m_row",      o_Row,      m_row);
      chk("m_phase",    o_Phase,    m_phase);
      chk("m_period",   o_Period,   m_period);
      chk("m_running",  o_Running,  (m_mode == M_RUN || m_mode == M_PAUSE));
      chk("m_underrun", o_Underrun, m_und);
      chk("m_level",    o_Level,    m_q.size());
      chk("m_next_row", o_Next_Row, exp_next);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick(input string name, input int bound);
    bit ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (o_Tick === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) timeout_fail(name, bound);
  endtask

  task automatic wait_running(input string name, input int bound);
    bit ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (o_Running === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) timeout_fail(name, bound);
  endtask

  task automatic wait_phase(input string name, input logic [31:0] ph, input int bound);
    bit ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (o_Phase === ph) begin ok = 1'b1; break; end
    end
    if (!ok) timeout_fail(name, bound);
  endtask

  task automatic pulse_hit();
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
  endtask

  initial begin
    int t0;
    int nt;
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; hit = 1'b0;
    rv = 1'b0; rval = 8'h00; speed = 2'b00;
    step(3);
    chk_en = 1'b1;
    chk("rst_period",  o_Period,  100);
    chk("rst_level",   o_Level,   0);
    chk("rst_running", o_Running, 0);
    chk("rst_tick",    o_Tick,    0);
    chk("rst_phase",   o_Phase,   0);

    // 2x speed, every random byte spawns a full row
    rst = 1'b0; speed = 2'b01; rv = 1'b1; rval = 8'hF8;
    step(1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_running("enter_run_a", 30);
    chk("prime_level", o_Level, 4);
    t0 = cyc;
    wait_tick("tick_a1", 200);
    chk("first_tick_latency", cyc - t0, 51);
    chk("row_a1", o_Row, 8'hFF);
    t0 = cyc;
    wait_tick("tick_a2", 200);
    chk("tick_interval", cyc - t0, 51);
    chk("row_a2", o_Row, 8'hFF);

    // stop and start together while running
    step(5);
    rv = 1'b0; stop = 1'b1; start = 1'b1;
    step(1);
    stop = 1'b0; start = 1'b0;
    chk("stop_running", o_Running, 0);
    chk("stop_level",   o_Level,   0);
    chk("stop_tick",    o_Tick,    0);
    chk("stop_phase",   o_Phase,   0);
    step(1);
    chk("stop_start_ignored", o_Running, 0);

    // 1x speed, hit overtaking the phase, then the ramp down to the floor
    speed = 2'b00; rv = 1'b1; rval = 8'h58;
    step(1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_running("enter_run_b", 30);
    chk("period_1x", o_Period, 100);
    wait_phase("phase_75", 32'd75, 200);
    pulse_hit();
    chk("hit_tick",   o_Tick,   1);
    chk("hit_phase",  o_Phase,  0);
    chk("hit_period", o_Period, 70);
    chk("hit_row",    o_Row,    8'h33);
    step(3);
    pulse_hit();
    chk("ramp_40", o_Period, 40);
    step(2);
    pulse_hit();
    chk("ramp_20", o_Period, 20);
    step(1);
    pulse_hit();
    chk("ramp_clamp", o_Period, 20);
    chk("ramp_no_tick", o_Tick, 0);

    // starve the FIFO: four buffered rows, then underruns
    rv = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      wait_tick("tick_drain", 40);
      chk("drain_row", o_Row, (k <= 4) ? 8'h33 : 8'h00);
      chk("drain_underrun", o_Underrun, (k <= 4) ? 1'b0 : 1'b1);
      if (k == 4) chk("drain_level", o_Level, 0);
    end

    // pause at phase 37 for 500 cycles
    stop = 1'b1;
    step(1);
    stop = 1'b0; rv = 1'b1; rval = 8'hF8;
    step(1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_running("enter_run_c", 30);
    wait_phase("phase_37", 32'd37, 200);
    pause = 1'b1;
    step(1);
    chk("pause_phase_start", o_Phase, 37);
    chk("pause_running", o_Running, 1);
    nt = 0;
    for (int i = 0; i < 499; i++) begin
      @(negedge clk);
      if (o_Tick === 1'b1) nt++;
    end
    chk("pause_no_tick", nt, 0);
    chk("pause_phase_end", o_Phase, 37);
    pause = 1'b0;
    step(1);
    chk("resume_hold", o_Phase, 37);
    step(1);
    chk("resume_phase", o_Phase, 38);

    // reset in the middle of a run
    step(10);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("midrst_running", o_Running, 0);
    chk("midrst_period",  o_Period,  100);
    chk("midrst_level",   o_Level,   0);
    chk("midrst_phase",   o_Phase,   0);
    step(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
